// File: rtl/axi_stream_strip_header_pkg.sv
// Shared types for the header-strip stage: packet-walk state encoding.
package axi_stream_strip_header_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_BODY  = 2'd2,
    ST_FLUSH = 2'd3
  } strip_state_t;

endpackage

// File: rtl/axi_stream_byte_realign.sv
// Combinational byte merge for header stripping: splits a beat at byte H and
// joins the carried residual (MSB-aligned) with the top H bytes of the new beat.
module axi_stream_byte_realign #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic [BYTE_CNT_WD:0] hdr_len,
  input  logic [DATA_WD-1:0]   residual,
  input  logic [DATA_WD-1:0]   data_in,
  output logic [DATA_WD-1:0]   merged,
  output logic [DATA_WD-1:0]   next_residual,
  output logic [DATA_WD-1:0]   header
);

  localparam int SHIFT_W = BYTE_CNT_WD + 4;
  localparam int CNT_W   = BYTE_CNT_WD + 1;

  logic [SHIFT_W-1:0] hdr_shift;
  logic [SHIFT_W-1:0] res_shift;

  // Residual occupies W-H bytes, so the new beat slides down by that amount.
  assign hdr_shift     = {1'b0, hdr_len, 3'b000};
  assign res_shift     = SHIFT_W'(DATA_WD) - hdr_shift;
  assign merged        = residual | (data_in >> res_shift);
  assign next_residual = data_in << hdr_shift;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_hdr_byte
      assign header[DATA_WD-1-8*gi -: 8] =
        (CNT_W'(gi) < hdr_len) ? data_in[DATA_WD-1-8*gi -: 8] : 8'h00;
    end
  endgenerate

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips a 1..DATA_BYTE_WD byte header from each AXI-Stream packet, returns it on a
// side channel and re-packs the remaining payload MSB-first onto full beats.
module axi_stream_strip_header
  import axi_stream_strip_header_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_strip,
  input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
  output logic                    ready_strip,
  output logic                    valid_hdr,
  output logic [DATA_WD-1:0]      data_hdr,
  output logic [DATA_BYTE_WD-1:0] keep_hdr,
  input  logic                    ready_hdr
);

  localparam int CNT_W = BYTE_CNT_WD + 1;

  function automatic logic [DATA_BYTE_WD-1:0] cnt_to_keep(input logic [CNT_W-1:0] n);
    logic [DATA_BYTE_WD-1:0] k;
    k = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++)
      if (CNT_W'(i) < n) k[DATA_BYTE_WD-1-i] = 1'b1;
    return k;
  endfunction

  function automatic logic [CNT_W-1:0] keep_to_cnt(input logic [DATA_BYTE_WD-1:0] k);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CNT_W'(k[i]);
    return c;
  endfunction

  function automatic logic [DATA_WD-1:0] keep_to_mask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  strip_state_t            state_reg, state_next;
  logic                    init_reg;
  logic [CNT_W-1:0]        h_reg, h_next;
  logic [DATA_WD-1:0]      res_reg, res_next;
  logic [CNT_W-1:0]        flush_cnt_reg, flush_cnt_next;
  logic                    valid_out_reg, valid_out_next;
  logic [DATA_WD-1:0]      data_out_reg, data_out_next;
  logic [DATA_BYTE_WD-1:0] keep_out_reg, keep_out_next;
  logic                    last_out_reg, last_out_next;
  logic                    valid_hdr_reg, valid_hdr_next;
  logic [DATA_WD-1:0]      data_hdr_reg, data_hdr_next;
  logic [DATA_BYTE_WD-1:0] keep_hdr_reg, keep_hdr_next;

  logic [CNT_W-1:0]   v_cnt;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_WD-1:0] data_masked;
  logic [DATA_WD-1:0] merged;
  logic [DATA_WD-1:0] next_residual;
  logic [DATA_WD-1:0] header;
  logic               out_free;
  logic               hdr_free;
  logic               in_fire;

  // Invalid bytes are zeroed up front so they never leak into residual or outputs.
  assign v_cnt       = keep_to_cnt(keep_in);
  assign r_cnt       = CNT_W'(DATA_BYTE_WD) - h_reg;
  assign data_masked = data_in & keep_to_mask(keep_in);
  assign out_free    = !valid_out_reg || ready_out;
  assign hdr_free    = !valid_hdr_reg || ready_hdr;
  assign in_fire     = valid_in && ready_in;

  axi_stream_byte_realign #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .BYTE_CNT_WD  (BYTE_CNT_WD)
  ) u_realign (
    .hdr_len       (h_reg),
    .residual      (res_reg),
    .data_in       (data_masked),
    .merged        (merged),
    .next_residual (next_residual),
    .header        (header)
  );

  always_comb begin
    state_next     = state_reg;
    h_next         = h_reg;
    res_next       = res_reg;
    flush_cnt_next = flush_cnt_reg;
    valid_out_next = valid_out_reg && !ready_out;
    data_out_next  = data_out_reg;
    keep_out_next  = keep_out_reg;
    last_out_next  = last_out_reg;
    valid_hdr_next = valid_hdr_reg && !ready_hdr;
    data_hdr_next  = data_hdr_reg;
    keep_hdr_next  = keep_hdr_reg;
    ready_in       = 1'b0;
    ready_strip    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        ready_strip = init_reg;
        if (valid_strip && init_reg) begin
          h_next     = {1'b0, byte_strip_cnt} + CNT_W'(1);
          state_next = ST_FIRST;
        end
      end
      ST_FIRST: begin
        ready_in = init_reg && hdr_free && out_free;
        if (in_fire) begin
          valid_hdr_next = 1'b1;
          data_hdr_next  = header;
          keep_hdr_next  = cnt_to_keep(h_reg);
          res_next       = next_residual;
          if (last_in) begin
            // A header-only packet produces no payload beat at all.
            if (v_cnt > h_reg) begin
              valid_out_next = 1'b1;
              data_out_next  = next_residual;
              keep_out_next  = cnt_to_keep(v_cnt - h_reg);
              last_out_next  = 1'b1;
            end
            state_next = ST_IDLE;
          end else begin
            state_next = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        ready_in = init_reg && out_free;
        if (in_fire) begin
          valid_out_next = 1'b1;
          data_out_next  = merged;
          keep_out_next  = '1;
          last_out_next  = 1'b0;
          res_next       = next_residual;
          if (last_in) begin
            if (v_cnt <= h_reg) begin
              keep_out_next = cnt_to_keep(r_cnt + v_cnt);
              last_out_next = 1'b1;
              state_next    = ST_IDLE;
            end else begin
              flush_cnt_next = v_cnt - h_reg;
              state_next     = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (out_free) begin
          valid_out_next = 1'b1;
          data_out_next  = res_reg;
          keep_out_next  = cnt_to_keep(flush_cnt_reg);
          last_out_next  = 1'b1;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      init_reg      <= 1'b0;
      h_reg         <= '0;
      res_reg       <= '0;
      flush_cnt_reg <= '0;
      valid_out_reg <= 1'b0;
      data_out_reg  <= '0;
      keep_out_reg  <= '0;
      last_out_reg  <= 1'b0;
      valid_hdr_reg <= 1'b0;
      data_hdr_reg  <= '0;
      keep_hdr_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      init_reg      <= 1'b1;
      h_reg         <= h_next;
      res_reg       <= res_next;
      flush_cnt_reg <= flush_cnt_next;
      valid_out_reg <= valid_out_next;
      data_out_reg  <= data_out_next;
      keep_out_reg  <= keep_out_next;
      last_out_reg  <= last_out_next;
      valid_hdr_reg <= valid_hdr_next;
      data_hdr_reg  <= data_hdr_next;
      keep_hdr_reg  <= keep_hdr_next;
    end
  end

  assign valid_out = valid_out_reg;
  assign data_out  = data_out_reg;
  assign keep_out  = keep_out_reg;
  assign last_out  = last_out_reg;
  assign valid_hdr = valid_hdr_reg;
  assign data_hdr  = data_hdr_reg;
  assign keep_hdr  = keep_hdr_reg;

endmodule
